mmu_tile_sched: RTL and testbench

- Sequences a full matrix-multiply job through the MMU datapath wrapper (valid/op_code/stage in, valid_out back), one tile at a time.
- Walks the weight/column tile loop (outer) and the input-row tile loop (inner), and issues buffer reads plus MMU valid pulses.
- The MMU cannot stall, so this block bounds the number of tiles in flight.
- Tags each returning result with its (row, col) tile index for the writeback unit, and reports job completion.

---
 rtl/mmu_tile_sched.sv | 174 +++++++++++++++++
 tb/tb_mmu_tile_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_tile_sched.sv
// mmu_tile_sched
//   Walks a matrix-multiply job over (row, col) tiles and feeds the MMU datapath.
//   The column loop is the outer loop and the row loop is the inner loop.
//   Each issued tile raises a buffer-read strobe, and the MMU valid pulse follows
//   one cycle later. The MMU cannot stall, so issue is limited to MAX_INFLIGHT
//   tiles that have been issued but not yet returned. Returning results are
//   tagged in order from a small tag FIFO.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_start / cfg_*            job start pulse and job configuration (used in IDLE)
//   abort                        stop issuing, drain in-flight tiles, then finish
//   issue_hold                   operand buffers not ready this cycle
//   busy, done, aborted          job status; done is a one-cycle pulse
//   buf_rd_en, buf_row, buf_col  operand buffer read strobe and tile index
//   mmu_valid_in, mmu_op_code,
//   mmu_stage                    MMU control
//   mmu_valid_out                MMU result strobe
//   res_valid, res_row, res_col  result tag for writeback
//   err_spurious                 sticky flag: MMU returned a result with nothing in flight
module mmu_tile_sched #(
  parameter int ROW_W        = 8,
  parameter int COL_W        = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [2:0]       cfg_op_code,
  input  logic [1:0]       cfg_stage,
  input  logic [ROW_W-1:0] cfg_row_tiles,
  input  logic [COL_W-1:0] cfg_col_tiles,
  input  logic             abort,
  input  logic             issue_hold,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             buf_rd_en,
  output logic [ROW_W-1:0] buf_row,
  output logic [COL_W-1:0] buf_col,
  output logic             mmu_valid_in,
  output logic [2:0]       mmu_op_code,
  output logic [1:0]       mmu_stage,
  input  logic             mmu_valid_out,
  output logic             res_valid,
  output logic [ROW_W-1:0] res_row,
  output logic [COL_W-1:0] res_col,
  output logic             err_spurious
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ROW_W + COL_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   rows_q, row_q;
  logic [COL_W-1:0]   cols_q, col_q;
  logic [2:0]         op_q;
  logic [1:0]         stage_q;
  logic               abort_flag_q;
  logic               valid_in_q;
  logic               err_q;
  logic [CNT_W-1:0]   inflight_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [TAG_W-1:0]   tag_mem [MAX_INFLIGHT];
  logic [TAG_W-1:0]   head_tag;

  logic issue, pop, row_last, last_tile;

  // The in-flight count covers the buffer-read cycle as well, so the tag FIFO
  // can never hold more than MAX_INFLIGHT entries.
  assign issue     = (state_q == S_ISSUE) && !issue_hold && !abort && (inflight_q < MAX_CNT);
  assign pop       = mmu_valid_out && (inflight_q != '0);
  assign row_last  = (row_q == rows_q - ROW_W'(1));
  assign last_tile = row_last && (col_q == cols_q - COL_W'(1));
  assign head_tag  = tag_mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = ((cfg_row_tiles == '0) || (cfg_col_tiles == '0)) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort || (issue && last_tile)) state_d = S_DRAIN;
      end
      // Wait until every issued tile has returned and no MMU valid pulse is still pending.
      S_DRAIN: begin
        if ((inflight_q == '0) && !valid_in_q) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rows_q       <= '0;
      cols_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      op_q         <= '0;
      stage_q      <= '0;
      abort_flag_q <= 1'b0;
      valid_in_q   <= 1'b0;
      err_q        <= 1'b0;
      inflight_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      valid_in_q <= issue;

      if ((state_q == S_IDLE) && cfg_start) begin
        rows_q       <= cfg_row_tiles;
        cols_q       <= cfg_col_tiles;
        op_q         <= cfg_op_code;
        stage_q      <= cfg_stage;
        row_q        <= '0;
        col_q        <= '0;
        abort_flag_q <= 1'b0;
      end

      if ((state_q == S_ISSUE) && abort) abort_flag_q <= 1'b1;

      // The row index is the inner loop; the column index advances when the row index wraps.
      if (issue) begin
        if (row_last) begin
          row_q <= '0;
          col_q <= col_q + COL_W'(1);
        end else begin
          row_q <= row_q + ROW_W'(1);
        end
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end

      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      case ({issue, pop})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase

      if (mmu_valid_out && (inflight_q == '0)) err_q <= 1'b1;
    end
  end

  // Tag storage has no reset; an entry is read only after it has been written.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr_q] <= {row_q, col_q};
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign aborted      = done && abort_flag_q;
  assign buf_rd_en    = issue;
  assign buf_row      = row_q;
  assign buf_col      = col_q;
  assign mmu_valid_in = valid_in_q;
  assign mmu_op_code  = op_q;
  assign mmu_stage    = stage_q;
  assign res_valid    = pop;
  assign res_row      = pop ? head_tag[TAG_W-1:COL_W] : '0;
  assign res_col      = pop ? head_tag[COL_W-1:0]     : '0;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_mmu_tile_sched.sv
module tb_mmu_tile_sched;

  localparam int MAXF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic [2:0] cfg_op_code = '0;
  logic [1:0] cfg_stage = '0;
  logic [7:0] cfg_row_tiles = '0;
  logic [7:0] cfg_col_tiles = '0;
  logic       abort = 1'b0;
  logic       issue_hold = 1'b0;
  logic       busy, done, aborted, buf_rd_en, mmu_valid_in, res_valid, err_spurious;
  logic [7:0] buf_row, buf_col, res_row, res_col;
  logic [2:0] mmu_op_code;
  logic [1:0] mmu_stage;
  logic       mmu_valid_out;

  always #5 clk = ~clk;

  mmu_tile_sched #(.ROW_W(8), .COL_W(8), .MAX_INFLIGHT(MAXF)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_op_code(cfg_op_code),
    .cfg_stage(cfg_stage), .cfg_row_tiles(cfg_row_tiles), .cfg_col_tiles(cfg_col_tiles),
    .abort(abort), .issue_hold(issue_hold), .busy(busy), .done(done), .aborted(aborted),
    .buf_rd_en(buf_rd_en), .buf_row(buf_row), .buf_col(buf_col),
    .mmu_valid_in(mmu_valid_in), .mmu_op_code(mmu_op_code), .mmu_stage(mmu_stage),
    .mmu_valid_out(mmu_valid_out), .res_valid(res_valid), .res_row(res_row),
    .res_col(res_col), .err_spurious(err_spurious)
  );

  // MMU model: fixed latency, in order, cannot stall.
  int          lat = 2;
  logic        spur = 1'b0;
  logic [31:0] pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[30:0], mmu_valid_in};
  end
  assign mmu_valid_out = pipe[lat-1] | spur;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected tile order, in issue order and in result order.
  logic [15:0] exp_issue_q[$];
  logic [15:0] exp_res_q[$];
  int n_issue, n_res, done_cnt, out_cnt, max_out, done_at, tcyc = 0;
  logic done_ab;

  always @(posedge clk) tcyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      int out_before;
      logic [15:0] t;
      out_before = out_cnt;
      if (buf_rd_en) begin
        chk("issue_under_hold", issue_hold, 1'b0);
        if (exp_issue_q.size() == 0) begin
          chk("issue_unexpected", {buf_row, buf_col}, 16'hxxxx);
        end else begin
          t = exp_issue_q.pop_front();
          chk("issue_tag", {buf_row, buf_col}, t);
        end
        n_issue++;
        out_cnt++;
        if (out_cnt > max_out) max_out = out_cnt;
      end
      if (mmu_valid_out) chk("res_valid_gate", res_valid, out_before > 0);
      if (res_valid) begin
        if (exp_res_q.size() == 0) begin
          chk("res_unexpected", {res_row, res_col}, 16'hxxxx);
        end else begin
          t = exp_res_q.pop_front();
          chk("res_tag", {res_row, res_col}, t);
        end
        n_res++;
        out_cnt--;
      end
      if (done) begin
        done_cnt++;
        done_ab = aborted;
        done_at = tcyc;
      end
    end
  end

  task automatic clear_model();
    exp_issue_q.delete();
    exp_res_q.delete();
    n_issue = 0; n_res = 0; done_cnt = 0; out_cnt = 0; max_out = 0; done_ab = 1'b0;
  endtask

  task automatic load_model(input int rows, input int cols);
    clear_model();
    for (int c = 0; c < cols; c++)
      for (int r = 0; r < rows; r++) begin
        exp_issue_q.push_back({8'(r), 8'(c)});
        exp_res_q.push_back({8'(r), 8'(c)});
      end
  endtask

  task automatic run_job(input string name, input int rows, input int cols, input int l,
                         input int hold_lo, input int hold_hi, input int abort_after,
                         input bit extra_start, input int exp_issues, input bit exp_ab);
    logic [2:0] op;
    logic [1:0] st;
    bit got, ab_sent;
    int start_at;
    op = 3'($urandom_range(0, 7));
    st = 2'($urandom_range(0, 3));
    lat = l;
    load_model(rows, cols);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_op_code = op; cfg_stage = st;
    cfg_row_tiles = 8'(rows); cfg_col_tiles = 8'(cols);
    start_at = tcyc;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    got = 1'b0; ab_sent = 1'b0;
    for (int cyc = 1; cyc < 3000 && !got; cyc++) begin
      issue_hold = (cyc >= hold_lo) && (cyc <= hold_hi);
      abort = (abort_after > 0) && (n_issue >= abort_after) && !ab_sent;
      if (abort) ab_sent = 1'b1;
      cfg_start = extra_start && (cyc == 3);
      if (cfg_start) begin
        cfg_row_tiles = 8'd7; cfg_col_tiles = 8'd7; cfg_op_code = ~op; cfg_stage = ~st;
      end
      if (cyc == 5) chk({name, "_opstage"}, {mmu_op_code, mmu_stage}, {op, st});
      @(posedge clk); #1;
      got = (done_cnt > 0);
    end
    issue_hold = 1'b0; abort = 1'b0; cfg_start = 1'b0;
    chk({name, "_finished"}, got, 1'b1);
    chk({name, "_busy_after"}, busy, 1'b0);
    chk({name, "_issues"}, n_issue, exp_issues);
    chk({name, "_results"}, n_res, n_issue);
    chk({name, "_aborted"}, done_ab, exp_ab);
    chk({name, "_max_out"}, max_out <= MAXF, 1'b1);
    chk({name, "_unissued"}, exp_res_q.size(), rows * cols - exp_issues);
    if (rows * cols == 0) chk({name, "_done_latency"}, (done_at - start_at) <= 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_single_done"}, done_cnt, 1);
    $display("job %s rows=%0d cols=%0d lat=%0d issues=%0d results=%0d aborted=%0b",
             name, rows, cols, l, n_issue, n_res, done_ab);
  endtask

  initial begin
    clear_model();
    #12;
    chk("reset_outputs", {busy, done, aborted, buf_rd_en, buf_row, buf_col, mmu_valid_in,
                          mmu_op_code, mmu_stage, res_valid, res_row, res_col, err_spurious}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_job("basic_3x2", 3, 2, 2, 0, -1, 0, 1'b0, 6, 1'b0);
    run_job("window_8x1", 8, 1, 10, 0, -1, 0, 1'b1, 8, 1'b0);
    chk("window_reaches_limit", max_out, MAXF);
    run_job("hold_4x1", 4, 1, 2, 2, 5, 0, 1'b0, 4, 1'b0);
    run_job("abort_10x1", 10, 1, 3, 0, -1, 3, 1'b0, 3, 1'b1);
    run_job("zero_rows", 0, 3, 2, 0, -1, 0, 1'b0, 0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      int r, c, l, lo;
      r = $urandom_range(1, 5);
      c = $urandom_range(1, 4);
      l = $urandom_range(1, 8);
      lo = $urandom_range(1, 6);
      run_job($sformatf("rand%0d", j), r, c, l, lo, lo + $urandom_range(0, 3), 0, 1'b0,
              r * c, 1'b0);
    end

    // Spurious MMU return while idle.
    clear_model();
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    chk("spurious_sticky", err_spurious, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("spurious_still_set", err_spurious, 1'b1);
    $display("spurious return err_spurious=%0b", err_spurious);

    // Reset in the middle of a job.
    lat = 4;
    load_model(5, 5);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_op_code = 3'd5; cfg_stage = 2'd2;
    cfg_row_tiles = 8'd5; cfg_col_tiles = 8'd5;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midjob_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midjob_reset_outputs", {busy, done, aborted, buf_rd_en, buf_row, buf_col, mmu_valid_in,
                                 mmu_op_code, mmu_stage, res_valid, res_row, res_col,
                                 err_spurious}, '0);
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, 0);
    chk("idle_after_reset", busy, 1'b0);
    $display("mid-job reset done_cnt=%0d busy=%0b", done_cnt, busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
